aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Iterative round sequencer for the AES-128 encryption datapath. It accepts one plaintext/key pair per transaction over a valid/ready handshake and applies the initial AddRoundKey. It then drives a single external combinational round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey plus one keyExpansion step) NR times, feeding the result back each cycle. The ciphertext is presented on a valid/ready output. It is the area-saving alternative to the fully unrolled stage pipeline and reuses the same round-number (`num`) convention for the key-expansion Rcon.

## Interface
- `NR`, default 10: number of rounds; legal range 1..15 (fits 4-bit `num`).
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input transaction valid.
- `in_ready`  out  1  controller can accept an input.
- `in_state`  in  128  plaintext block.
- `in_key`  in  128  cipher key (round-0 key).
- `rd_state`  out  128  state presented to the round datapath.
- `rd_key`  out  128  current round key presented to the round datapath.
- `rd_num`  out  4  round number 1..NR (Rcon index for keyExpansion).
- `rd_last`  out  1  high when `rd_num == NR`; the datapath skips MixColumns.
- `rd_en`  out  1  high in every cycle the datapath result is being consumed.
- `rd_state_res`  in  128  datapath state result (combinational from `rd_*`).
- `rd_key_res`  in  128  datapath next round key.
- `out_valid`  out  1  ciphertext valid.
- `out_ready`  in  1  downstream accepts ciphertext.
- `out_state`  out  128  ciphertext.
- `busy`  out  1  high in ROUND or DONE.

## Operation
- Registers: `st` (IDLE/ROUND/DONE), `state_r[127:0]`, `key_r[127:0]`, `num_r[3:0]`.
- `rd_state = state_r`, `rd_key = key_r`, `rd_num = num_r`, `rd_last = (st==ROUND) & (num_r==NR)`, `rd_en = (st==ROUND)`, `out_state = state_r`.
- `in_ready = (st==IDLE) | (st==DONE & out_ready)`; `out_valid = (st==DONE)`; `busy = (st!=IDLE)`.
- Accept (`in_valid & in_ready`), from IDLE or from DONE:
  - `state_r <= in_state ^ in_key`, `key_r <= in_key`, `num_r <= 1`, `st <= ROUND`.
- ROUND, each cycle:
  - `state_r <= rd_state_res`, `key_r <= rd_key_res`.
  - If `num_r==NR`: `st <= DONE`; `num_r` holds.
  - Else: `num_r <= num_r+1`.
  - `in_valid` is ignored; `in_ready` is low.
- DONE:
  - `state_r`, `key_r` and `num_r` hold until `out_ready`.
  - On `out_ready` with no accept: `st <= IDLE`.
  - On `out_ready` with an accept in the same cycle: load the new transaction and go straight to ROUND (back-to-back).
- IDLE with no accept: all registers hold; `rd_en` low. Datapath inputs are don't-care to the datapath but stable.
- `num_r` never wraps: the maximum value is NR ≤ 15, and the increment is suppressed at NR.
- `out_state` is stable while `out_valid` is high and `out_ready` is low. Input data is sampled only on the accept cycle.

## Timing
- Reset (`rst` high at a clock edge): `st=IDLE`, `state_r=0`, `key_r=0`, `num_r=0`.
  - Outputs after reset: `in_ready=1`, `out_valid=0`, `busy=0`, `rd_en=0`, `rd_last=0`, `rd_num=0`, `rd_state=0`, `rd_key=0`, `out_state=0`.
- Reset mid-ROUND or mid-DONE aborts the transaction. The result is discarded and never presented, and the state at the next edge is IDLE.
- `rst` has priority over accept and over all state updates.
- Latency: accept at edge T; rounds consume at edges T+1..T+NR; `out_valid` high after edge T+NR (NR+1 cycles from accept to valid).
- Throughput with `out_ready` held high: one block every NR+1 cycles (back-to-back accept in DONE).
- `out_ready` low holds DONE indefinitely; no data loss.
- `rd_state_res`/`rd_key_res` must settle within one cycle; the controller places no register between `rd_*` and `*_res`.

## Test plan
- **Reset values:** hold `rst` for 2 cycles → `in_ready=1`, `out_valid=0`, `busy=0`, `rd_en=0`, all data outputs 0.
- **FIPS-197 C.1 vector:** bench round model attached, NR=10; `in_key=000102030405060708090a0b0c0d0e0f`, `in_state=00112233445566778899aabbccddeeff`, `out_ready=1` → `out_valid` exactly 11 cycles after accept with `out_state=69c4e0d86a7b0430d8cdb78070b4c55a`. `rd_num` sequences 1..10 and `rd_last` is high only at 10.
- **Back-to-back:** two C.1 transactions with `in_valid` held and `out_ready=1` → second accept occurs in the DONE cycle of the first; outputs spaced 11 cycles apart, both correct.
- **Backpressure:** `out_ready=0` for 5 cycles after `out_valid` → `out_valid` stays high, `out_state` stable, `in_ready=0`. Raising `out_ready` gives a one-cycle handshake, then IDLE.
- **Input ignored while busy:** toggle `in_valid` with different data during ROUND → `in_ready=0`, result unchanged (C.1 ciphertext).
- **Abort:** assert `rst` at `rd_num=5` → next cycle IDLE with all outputs at reset values; a new C.1 transaction then completes correctly.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: loads a block with the initial AddRoundKey,
// then loops the state and key through one external round datapath NR times.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  output logic [127:0] rd_state,
  output logic [127:0] rd_key,
  output logic [3:0]   rd_num,
  output logic         rd_last,
  output logic         rd_en,
  input  logic [127:0] rd_state_res,
  input  logic [127:0] rd_key_res,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_DONE
  } st_e;

  localparam logic [3:0] NUM_LAST = 4'(NR);

  st_e          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   num_q, num_d;
  logic         accept;

  // DONE with out_ready can take the next block in the same cycle (back-to-back).
  assign in_ready  = (st_q == ST_IDLE) | ((st_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;

  assign rd_state  = state_q;
  assign rd_key    = key_q;
  assign rd_num    = num_q;
  assign rd_en     = (st_q == ST_ROUND);
  assign rd_last   = (st_q == ST_ROUND) & (num_q == NUM_LAST);
  assign out_valid = (st_q == ST_DONE);
  assign out_state = state_q;
  assign busy      = (st_q != ST_IDLE);

  always_comb begin
    // NOTE: every next-state variable defaults to hold first, so no branch can infer a latch.
    st_d    = st_q;
    state_d = state_q;
    key_d   = key_q;
    num_d   = num_q;

    if (accept) begin
      state_d = in_state ^ in_key;
      key_d   = in_key;
      num_d   = 4'd1;
      st_d    = ST_ROUND;
    end else begin
      case (st_q)
        ST_ROUND: begin
          state_d = rd_state_res;
          key_d   = rd_key_res;
          if (num_q == NUM_LAST) begin
            st_d = ST_DONE;
          end else begin
            num_d = num_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            st_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      st_q    <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      num_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      num_q   <= num_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: acts as the AES round datapath and scoreboards the
// ciphertexts against FIPS-197 known answers.
module tb_aes_round_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [127:0] in_state, in_key;
  logic [127:0] rd_state, rd_key, rd_state_res, rd_key_res;
  logic [3:0]   rd_num;
  logic         rd_last, rd_en;
  logic         out_valid, out_ready;
  logic [127:0] out_state;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [127:0] exp_next;
  logic [127:0] sb_q[$];

  aes_round_ctrl #(.NR(NR)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .in_key(in_key),
    .rd_state(rd_state), .rd_key(rd_key), .rd_num(rd_num), .rd_last(rd_last), .rd_en(rd_en),
    .rd_state_res(rd_state_res), .rd_key_res(rd_key_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- AES round datapath model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: x^254 in GF(2^8) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] r, base, e;
    r = 8'h01; base = b; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [3:0] num);
    logic [7:0]  rc;
    logic [31:0] rot, t, n0, n1, n2, n3;
    rc = 8'h01;
    for (int i = 1; i < int'(num); i++) rc = xt(rc);
    rot = {k[23:0], k[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [127:0] sb, sr, mc;
    logic [7:0] a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[127-32*c -: 8];      a1 = sr[119-32*c -: 8];
      a2 = sr[111-32*c -: 8];      a3 = sr[103-32*c -: 8];
      mc[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return (last ? sr : mc) ^ k;
  endfunction

  assign rd_key_res   = key_exp(rd_key, rd_num);
  assign rd_state_res = round_fn(rd_state, rd_key_res, rd_last);

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"},  in_ready,  1);
    check({pfx, "_out_valid"}, out_valid, 0);
    check({pfx, "_busy"},      busy,      0);
    check({pfx, "_rd_en"},     rd_en,     0);
    check({pfx, "_rd_last"},   rd_last,   0);
    check({pfx, "_rd_num"},    rd_num,    0);
    check({pfx, "_rd_state"},  rd_state,  0);
    check({pfx, "_rd_key"},    rd_key,    0);
    check({pfx, "_out_state"}, out_state, 0);
  endtask

  // Ticks until out_valid (bounded) and checks the cycle count.
  task automatic wait_valid(input string tag, input int exp_cycles);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, n, exp_cycles);
  endtask

  task automatic drive(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct);
    in_valid = 1'b1;
    in_state = pt;
    in_key   = key;
    exp_next = ct;
  endtask

  // Scoreboard: looks half a cycle ahead at the handshakes the next edge will take.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", out_state, '1);
        end else begin
          check("sb_ciphertext", out_state, sb_q.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) sb_q.push_back(exp_next);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_state = '0; in_key = '0; exp_next = '0;

    // Reset values
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // FIPS-197 C.1, per-round sequencing and latency
    drive(C1_PT, C1_KEY, C1_CT);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("c1_busy", busy, 1);
    for (int r = 1; r <= NR; r++) begin
      check($sformatf("c1_rd_num_%0d", r), rd_num, r);
      check($sformatf("c1_rd_last_%0d", r), rd_last, (r == NR));
      check($sformatf("c1_rd_en_%0d", r), rd_en, 1);
      check($sformatf("c1_in_ready_%0d", r), in_ready, 0);
      check($sformatf("c1_out_valid_%0d", r), out_valid, 0);
      tick();
    end
    check("c1_out_valid", out_valid, 1);
    check("c1_done_rd_en", rd_en, 0);
    check("c1_done_rd_last", rd_last, 0);
    check("c1_out_state", out_state, C1_CT);
    tick();
    check("c1_idle_out_valid", out_valid, 0);
    check("c1_idle_busy", busy, 0);

    // Back-to-back: in_valid held, second accept in the DONE cycle of the first
    drive(C1_PT, C1_KEY, C1_CT);
    tick();
    wait_valid("b2b_first_latency", NR);
    check("b2b_done_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("b2b_second_accepted_busy", busy, 1);
    check("b2b_second_rd_num", rd_num, 1);
    check("b2b_second_out_valid", out_valid, 0);
    wait_valid("b2b_second_latency", NR);
    tick();
    check("b2b_idle_busy", busy, 0);

    // Backpressure with the FIPS-197 appendix B vector
    drive(B_PT, B_KEY, B_CT);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_valid("bp_latency", NR);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_out_valid_%0d", i), out_valid, 1);
      check($sformatf("bp_out_state_%0d", i), out_state, B_CT);
      check($sformatf("bp_in_ready_%0d", i), in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    tick();
    check("bp_idle_out_valid", out_valid, 0);
    check("bp_idle_busy", busy, 0);

    // Input toggled with junk data while busy must be ignored
    drive(C1_PT, C1_KEY, C1_CT);
    tick();
    for (int i = 0; i < NR; i++) begin
      in_valid = i[0];
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_key   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      check($sformatf("ign_in_ready_%0d", i), in_ready, 0);
      tick();
    end
    in_valid = 1'b0;
    check("ign_out_valid", out_valid, 1);
    check("ign_out_state", out_state, C1_CT);
    tick();

    // Abort at round 5, then a clean transaction
    drive(C1_PT, C1_KEY, C1_CT);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && rd_num != 4'd5; i++) tick();
    check("abort_rd_num", rd_num, 5);
    rst = 1'b1;
    tick();
    check_reset_outputs("abort");
    rst = 1'b0;
    drive(C1_PT, C1_KEY, C1_CT);
    tick();
    in_valid = 1'b0;
    wait_valid("abort_retry_latency", NR);
    check("abort_retry_out_state", out_state, C1_CT);
    tick();

    // Every accepted, non-aborted block came out exactly once
    check("outputs_seen", n_out, 6);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
